tpram_gen2: RTL and testbench
=============================

# tpram_gen2

Parametrised second-generation two-port RAM: one write channel (A) and one read channel (B) on a single clock. Adds configurable width, depth and read latency, byte-enable writes, and a selectable read-during-write policy. Also provides a post-reset zeroing sweep and same-address collision reporting. Drop-in storage for buffering and datapath blocks that need deterministic contents after reset.

## Interface
- DW, 16, data width in bits; must be a multiple of 8
- AW, 8, address width; DEPTH = 2**AW words
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new data (write-through)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wea  in  1  write enable, channel A
- bea  in  DW/8  byte enables for the channel A write; bit i covers data bits [8i+7:8i]
- addra  in  AW  write address
- data_i_a  in  DW  write data
- enb  in  1  read enable, channel B
- addrb  in  AW  read address
- data_o_b  out  DW  read data
- valid_o_b  out  1  one-cycle pulse marking new read data
- collision_o  out  1  one-cycle pulse marking a same-address read/write
- coll_cnt  out  16  saturating collision counter
- clr_cnt  in  1  synchronous clear of coll_cnt
- busy_o  out  1  high while the zeroing sweep runs

## Operation
- Two-state FSM, INIT and RUN; reset enters INIT.
- INIT:
  - A counter steps from 0 to DEPTH-1 and writes all-zero to one word per cycle.
  - After the write to DEPTH-1 completes, the FSM moves to RUN.
  - wea, enb and clr_cnt are ignored; no valid_o_b or collision_o pulses are produced.
- RUN, write: on a clock with wea=1, the bytes of data_i_a selected by bea are written to addra. Unselected bytes keep their contents. wea=1 with bea=0 changes nothing.
- RUN, read: on a clock with enb=1, the word at addrb is read. After RD_LAT clocks, data_o_b is updated and valid_o_b pulses.
- data_o_b holds its last value when no read completes.
- Collision: wea=1, enb=1 and addra==addrb on the same clock, in RUN.
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word (new bytes where bea=1, old bytes elsewhere).
  - The write always commits.
  - collision_o pulses on the same cycle as that read's valid_o_b.
  - coll_cnt increments on the collision_o pulse cycle and saturates at 16'hFFFF.
- clr_cnt=1 zeroes coll_cnt on the next clock. If an increment falls on the same clock, the clear wins and the result is 0.
- Reads and writes to different addresses in the same cycle are independent.

## Timing
- Reset values:
  - data_o_b = 0, valid_o_b = 0, collision_o = 0, coll_cnt = 0, busy_o = 1.
  - Sweep counter = 0; FSM = INIT; read pipeline flushed.
- The sweep starts on the first rising edge after rst_n deasserts and occupies exactly DEPTH clocks.
- busy_o falls after the DEPTH-th sweep edge. The first accepted access is on the next edge.
- Read latency: enb sampled at edge N produces data_o_b/valid_o_b valid after edge N+RD_LAT.
- Throughput is one read and one write per cycle with no stalls.
- Back-to-back reads give contiguous valid_o_b pulses.
- Read-after-write to the same address one or more cycles later returns the written data. This holds in both modes.
- Reset mid-operation:
  - Applies immediately (asynchronous): all outputs return to reset values and in-flight reads are discarded.
  - The sweep restarts from address 0 on release.
  - A sweep interrupted by reset is restarted in full.
- No assertion of enb during INIT ever yields a valid_o_b pulse, including reads issued on the last INIT cycle.

## Test plan
- Reset then idle, DW=16, AW=4 -> busy_o high for exactly 16 clocks, then low. Reads of all 16 addresses return 16'h0000, one valid_o_b each.
- RUN, write 16'hABCD to addr 3 with bea=2'b11, then bea=2'b01 with 16'h1234 -> read of addr 3 returns 16'hAB34. With RD_LAT=2, data arrives 2 clocks after enb.
- Collision: addr 5 holds 16'h1111; wea=1, enb=1, addra=addrb=5, data 16'h2222 in one cycle.
  - RDW_MODE=0 -> read returns 16'h1111.
  - RDW_MODE=1 -> read returns 16'h2222.
  - Both modes -> collision_o pulses with valid_o_b, coll_cnt=1, and a later read returns 16'h2222.
- Counter edges:
  - Force 65537 collisions -> coll_cnt=16'hFFFF.
  - clr_cnt asserted together with a collision -> coll_cnt=0.
- Reset mid-stream: assert rst_n=0 while 2 reads are in flight (RD_LAT=2) -> outputs drop to 0 immediately and no valid_o_b appears after release. busy_o stays high for a full DEPTH clocks, and previously written data reads back as 0.

Source files
------------

// File: rtl/tpram_gen2.sv
// Two-port RAM (one write, one read, single clock) with byte enables, a configurable
// read latency and read-during-write policy, a post-reset zeroing sweep and a collision counter.
module tpram_gen2 #(
    parameter int DW       = 16,
    parameter int AW       = 8,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wea,
    input  logic [DW/8-1:0]   bea,
    input  logic [AW-1:0]     addra,
    input  logic [DW-1:0]     data_i_a,
    input  logic              enb,
    input  logic [AW-1:0]     addrb,
    output logic [DW-1:0]     data_o_b,
    output logic              valid_o_b,
    output logic              collision_o,
    output logic [15:0]       coll_cnt,
    input  logic              clr_cnt,
    output logic              busy_o
);

    localparam int NB = DW / 8;
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Overlay the byte lanes of new_w selected by be onto old_w.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [NB-1:0] be);
        logic [DW-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_e               state_q, state_d;
    logic [AW-1:0]        sweep_q, sweep_d;
    logic [DW-1:0]        mem_q [2**AW];
    logic [RD_LAT:0]      vld_q;
    logic [RD_LAT:0]      coll_q;
    logic [RD_LAT:0][DW-1:0] data_q;
    logic [15:0]          cnt_q, cnt_d;

    logic                 run_s;
    logic                 fire_s;
    logic                 coll_s;
    logic                 mem_we_s;
    logic [AW-1:0]        mem_waddr_s;
    logic [DW-1:0]        mem_wdata_s;
    logic [DW-1:0]        merged_s;
    logic [DW-1:0]        rd_word_s;

    assign run_s  = (state_q == ST_RUN);
    assign fire_s = run_s & enb;
    assign coll_s = fire_s & wea & (addra == addrb);

    // FSM state and sweep address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Sweep one word per clock in INIT, leave after the last address is written
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + ADDR_ONE;
                if (sweep_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                sweep_d = '0;
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Write-port mux (sweep vs. user write) and read-word selection for the RDW policy
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = sweep_q;
        mem_wdata_s = '0;
        merged_s    = merge_bytes(mem_q[addra], data_i_a, bea);
        if (run_s) begin
            mem_we_s    = wea & (|bea);
            mem_waddr_s = addra;
            mem_wdata_s = merged_s;
        end else begin
            mem_we_s    = 1'b1;
            mem_waddr_s = sweep_q;
            mem_wdata_s = '0;
        end
        // On a collision merged_s is the word at addrb after this write commits
        if ((RDW_MODE != 32'sd0) && coll_s) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = mem_q[addrb];
        end
    end

    // Storage array; contents are made deterministic by the sweep, not by reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Read pipeline: stage 0 captures the read, output is stage RD_LAT; data holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            coll_q <= '0;
            data_q <= '0;
        end else begin
            vld_q[0]  <= fire_s;
            coll_q[0] <= coll_s;
            if (fire_s) begin
                data_q[0] <= rd_word_s;
            end
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                coll_q[i] <= coll_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    // Counter advances on the edge that raises collision_o; a clear on that edge wins
    always_comb begin
        cnt_d = cnt_q;
        if (run_s && clr_cnt) begin
            cnt_d = '0;
        end else if (coll_q[RD_LAT-1] && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Collision counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign data_o_b    = data_q[RD_LAT];
    assign valid_o_b   = vld_q[RD_LAT];
    assign collision_o = coll_q[RD_LAT];
    assign coll_cnt    = cnt_q;
    assign busy_o      = (state_q == ST_INIT);

endmodule

// File: tb/tb_tpram_gen2.sv
// Bench for tpram_gen2: two instances (RD_LAT=2/old-data and RD_LAT=1/new-data) driven in
// parallel and checked every cycle against a queue-based behavioural model.
module tb_tpram_gen2;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wea = 1'b0;
    logic [1:0]  bea = 2'b00;
    logic [3:0]  addra = 4'd0;
    logic [15:0] data_i_a = 16'h0000;
    logic        enb = 1'b0;
    logic [3:0]  addrb = 4'd0;
    logic        clr_cnt = 1'b0;

    logic [1:0][15:0] dout;
    logic [1:0][15:0] cnt;
    logic [1:0]       vld;
    logic [1:0]       coll;
    logic [1:0]       busy;

    always #5 clk = ~clk;

    tpram_gen2 #(.DW(16), .AW(4), .RD_LAT(2), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wea(wea), .bea(bea), .addra(addra), .data_i_a(data_i_a),
        .enb(enb), .addrb(addrb), .data_o_b(dout[0]), .valid_o_b(vld[0]),
        .collision_o(coll[0]), .coll_cnt(cnt[0]), .clr_cnt(clr_cnt), .busy_o(busy[0])
    );

    tpram_gen2 #(.DW(16), .AW(4), .RD_LAT(1), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wea(wea), .bea(bea), .addra(addra), .data_i_a(data_i_a),
        .enb(enb), .addrb(addrb), .data_o_b(dout[1]), .valid_o_b(vld[1]),
        .collision_o(coll[1]), .coll_cnt(cnt[1]), .clr_cnt(clr_cnt), .busy_o(busy[1])
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        logic [15:0] r;
        r = o;
        if (be[0]) r[7:0]  = n[7:0];
        if (be[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    // Behavioural model: array memory, pending reads tagged with their due cycle.
    typedef struct {
        int          due;
        int          k;
        logic [15:0] d;
        bit          c;
    } rd_t;

    rd_t         pend[$];
    rd_t         rest[$];
    rd_t         r;
    logic [15:0] m_mem [DEPTH];
    bit          m_init;
    int          m_sweep;
    int          m_cyc;
    int          lat [2] = '{2, 1};
    bit          mode[2] = '{1'b0, 1'b1};
    logic [15:0] e_data[2];
    logic [15:0] e_cnt [2];
    bit          e_vld [2];
    bit          e_coll[2];
    logic [15:0] m_old, m_mrg;
    bit          m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init = 1'b1;
            m_sweep = 0;
            m_cyc = 0;
            pend.delete();
            for (int k = 0; k < 2; k++) begin
                e_data[k] = 16'h0000; e_cnt[k] = 16'h0000; e_vld[k] = 1'b0; e_coll[k] = 1'b0;
            end
        end else begin
            m_cyc++;
            for (int k = 0; k < 2; k++) begin
                e_vld[k] = 1'b0; e_coll[k] = 1'b0;
            end
            if (m_init) begin
                m_mem[m_sweep] = 16'h0000;
                m_sweep++;
                if (m_sweep == DEPTH) m_init = 1'b0;
            end else begin
                if (enb) begin
                    m_old = m_mem[addrb];
                    m_mrg = merge(m_old, data_i_a, bea);
                    m_c   = wea && (addra == addrb);
                    for (int k = 0; k < 2; k++) begin
                        r.due = m_cyc + lat[k];
                        r.k   = k;
                        r.d   = (mode[k] && m_c) ? m_mrg : m_old;
                        r.c   = m_c;
                        pend.push_back(r);
                    end
                end
                if (wea) m_mem[addra] = merge(m_mem[addra], data_i_a, bea);
                rest.delete();
                foreach (pend[i]) begin
                    if (pend[i].due == m_cyc) begin
                        e_vld[pend[i].k]  = 1'b1;
                        e_data[pend[i].k] = pend[i].d;
                        e_coll[pend[i].k] = pend[i].c;
                    end else begin
                        rest.push_back(pend[i]);
                    end
                end
                pend = rest;
                for (int k = 0; k < 2; k++) begin
                    if (clr_cnt) e_cnt[k] = 16'h0000;
                    else if (e_coll[k] && e_cnt[k] != 16'hFFFF) e_cnt[k] = e_cnt[k] + 16'd1;
                end
            end
        end
    end

    int          vcnt[2] = '{0, 0};
    int          ccnt[2] = '{0, 0};
    logic [15:0] last_rd[2] = '{16'h0000, 16'h0000};

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("data_o_b", k, dout[k], e_data[k]);
            chk("valid_o_b", k, vld[k], e_vld[k]);
            chk("collision_o", k, coll[k], e_coll[k]);
            chk("coll_cnt", k, cnt[k], e_cnt[k]);
            chk("busy_o", k, busy[k], m_init);
            if (vld[k]) begin
                vcnt[k]++;
                last_rd[k] = dout[k];
            end
            if (coll[k]) ccnt[k]++;
        end
    end

    task automatic op(input bit w, input logic [1:0] be, input logic [3:0] aa, input logic [15:0] da,
                      input bit e, input logic [3:0] ab, input bit cl);
        wea = w; bea = be; addra = aa; data_i_a = da; enb = e; addrb = ab; clr_cnt = cl;
        @(posedge clk);
        #1;
        wea = 1'b0; enb = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0);
    endtask

    // Called right after reset release: busy must last DEPTH clocks, INIT traffic ignored.
    task automatic sweep_check(input string nm);
        int bc[2];
        int v0[2];
        for (int k = 0; k < 2; k++) begin
            bc[k] = int'(busy[k]);
            v0[k] = vcnt[k];
        end
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b1, 2'b11, 4'(i), 16'hFFFF, 1'b1, 4'(i), 1'b1);
            for (int k = 0; k < 2; k++) bc[k] += int'(busy[k]);
        end
        idle(4);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_busy_clocks"}, k, bc[k], 32'd16);
            chk({nm, "_busy_low"}, k, busy[k], 32'd0);
            chk({nm, "_no_init_valid"}, k, vcnt[k] - v0[k], 32'd0);
        end
    endtask

    int v0[2];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_data", k, dout[k], 32'h0);
            chk("rst_valid", k, vld[k], 32'h0);
            chk("rst_busy", k, busy[k], 32'h1);
            chk("rst_cnt", k, cnt[k], 32'h0);
        end
        rst_n = 1'b1;
        sweep_check("init");

        // All addresses read back as zero, one valid each.
        for (int k = 0; k < 2; k++) v0[k] = vcnt[k];
        for (int i = 0; i < DEPTH; i++) op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'(i), 1'b0);
        idle(4);
        for (int k = 0; k < 2; k++) begin
            chk("zero_reads", k, vcnt[k] - v0[k], 32'd16);
            chk("zero_data", k, last_rd[k], 32'h0);
        end

        // Byte-enable merge and latency.
        op(1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, 4'd0, 1'b0);
        op(1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, 4'd0, 1'b0);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0);
        chk("lat_n0", 0, vld[0], 32'd0);
        chk("lat_n0", 1, vld[1], 32'd0);
        idle(1);
        chk("lat_n1", 1, vld[1], 32'd1);
        chk("be_merge", 1, dout[1], 32'hAB34);
        chk("lat_n1", 0, vld[0], 32'd0);
        idle(1);
        chk("lat_n2", 0, vld[0], 32'd1);
        chk("be_merge", 0, dout[0], 32'hAB34);
        idle(3);

        // Collision in both read-during-write modes.
        op(1'b1, 2'b11, 4'd5, 16'h1111, 1'b0, 4'd0, 1'b0);
        op(1'b1, 2'b11, 4'd5, 16'h2222, 1'b1, 4'd5, 1'b0);
        idle(4);
        chk("coll_old_data", 0, last_rd[0], 32'h1111);
        chk("coll_new_data", 1, last_rd[1], 32'h2222);
        for (int k = 0; k < 2; k++) begin
            chk("coll_cnt_one", k, cnt[k], 32'd1);
            chk("coll_pulses", k, ccnt[k], 32'd1);
        end
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b0);
        idle(4);
        for (int k = 0; k < 2; k++) chk("coll_committed", k, last_rd[k], 32'h2222);

        // Randomized traffic on a narrow address window to provoke collisions.
        repeat (2000) begin
            op(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               16'($urandom), ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 3)),
               ($urandom_range(0, 15) == 0));
        end
        idle(4);

        // Clear coinciding with an increment.
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1);
        op(1'b1, 2'b11, 4'd6, 16'h0606, 1'b1, 4'd6, 1'b0);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1);
        idle(4);
        chk("clr_wins", 1, cnt[1], 32'd0);
        chk("clr_then_inc", 0, cnt[0], 32'd1);
        op(1'b1, 2'b11, 4'd6, 16'h0707, 1'b1, 4'd6, 1'b0);
        idle(1);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1);
        idle(4);
        chk("clr_wins", 0, cnt[0], 32'd0);
        chk("inc_then_clr", 1, cnt[1], 32'd0);

        // Saturation: 65534 then 3 more collisions (65537 total).
        repeat (65534) op(1'b1, 2'b11, 4'd9, 16'h0909, 1'b1, 4'd9, 1'b0);
        idle(4);
        for (int k = 0; k < 2; k++) chk("cnt_fffe", k, cnt[k], 32'hFFFE);
        repeat (3) op(1'b1, 2'b11, 4'd9, 16'h0909, 1'b1, 4'd9, 1'b0);
        idle(4);
        for (int k = 0; k < 2; k++) chk("cnt_sat", k, cnt[k], 32'hFFFF);

        // Reset with reads in flight.
        op(1'b1, 2'b11, 4'd7, 16'h5A5A, 1'b0, 4'd0, 1'b0);
        idle(1);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0);
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0);
        chk("pre_rst_data", 1, dout[1], 32'h5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_data", k, dout[k], 32'h0);
            chk("async_rst_valid", k, vld[k], 32'h0);
            chk("async_rst_coll", k, coll[k], 32'h0);
            chk("async_rst_cnt", k, cnt[k], 32'h0);
            chk("async_rst_busy", k, busy[k], 32'h1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check("rerst");
        for (int k = 0; k < 2; k++) v0[k] = vcnt[k];
        op(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0);
        idle(4);
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_reads", k, vcnt[k] - v0[k], 32'd1);
            chk("post_rst_zeroed", k, last_rd[k], 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
